// File: rtl/sd_word_scheduler_if.sv
// Config handshake bundle between a config source and sd_word_scheduler.
interface sd_word_scheduler_if #(
    parameter int unsigned BITWIDTH = 40,
    parameter int unsigned CNTW     = 16
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [BITWIDTH-1:0] cfg_k1;
    logic [BITWIDTH-1:0] cfg_k2;
    logic [CNTW-1:0]     cfg_n1;
    logic [CNTW-1:0]     cfg_n2;

    modport master (output cfg_valid, cfg_k1, cfg_k2, cfg_n1, cfg_n2, input cfg_ready);
    modport slave  (input cfg_valid, cfg_k1, cfg_k2, cfg_n1, cfg_n2, output cfg_ready);
endinterface

// File: rtl/sd_word_scheduler.sv
// Two-word sigma-delta sequencer: alternates kin1/kin2 dwell windows per period and
// swaps double-buffered config only at period boundaries.
module sd_word_scheduler #(
    parameter int unsigned BITWIDTH   = 40,
    parameter int unsigned CNTW       = 16,
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    sd_word_scheduler_if.slave  cfg,
    output logic [BITWIDTH-1:0] kin1,
    output logic [BITWIDTH-1:0] kin2,
    output logic                muxin1,
    output logic                sd_reset,
    output logic                period_tick,
    output logic                busy
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_DWELL1 = 2'd2;
    localparam logic [1:0] ST_DWELL2 = 2'd3;

    logic [1:0]          state, state_d;
    logic [CNTW-1:0]     cnt, cnt_d;
    logic [CNTW-1:0]     act_n1, act_n2, sh_n1, sh_n2, n1_use, n2_use;
    logic [BITWIDTH-1:0] sh_k1, sh_k2;
    logic                pending, active_valid, ready_q;
    logic                accept, swap, new_period, tick_d;

    assign cfg.cfg_ready = ready_q;
    assign accept        = cfg.cfg_valid && ready_q;

    // Next state; a boundary edge with a pending shadow starts the new period on the new dwells.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        new_period = 1'b0;
        swap       = pending && ((state == ST_IDLE) || period_tick);
        n1_use     = swap ? sh_n1 : act_n1;
        n2_use     = swap ? sh_n2 : act_n2;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active_valid) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNTW'(RESET_HOLD);
                    end
                end
                ST_FLUSH: begin
                    if (cnt == CNTW'(1)) new_period = 1'b1;
                    else                 cnt_d = cnt - CNTW'(1);
                end
                ST_DWELL1: begin
                    if (cnt != CNTW'(1)) begin
                        cnt_d = cnt - CNTW'(1);
                    end else if (act_n2 == '0) begin
                        new_period = 1'b1;
                    end else begin
                        state_d = ST_DWELL2;
                        cnt_d   = act_n2;
                    end
                end
                ST_DWELL2: begin
                    if (cnt == CNTW'(1)) new_period = 1'b1;
                    else                 cnt_d = cnt - CNTW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
            if (new_period) begin
                if (n1_use != '0) begin
                    state_d = ST_DWELL1;
                    cnt_d   = n1_use;
                end else begin
                    state_d = ST_DWELL2;
                    cnt_d   = n2_use;
                end
            end
        end
        tick_d = (cnt_d == CNTW'(1)) &&
                 ((state_d == ST_DWELL2) || ((state_d == ST_DWELL1) && (n2_use == '0)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            kin1         <= '0;
            kin2         <= '0;
            act_n1       <= '0;
            act_n2       <= '0;
            sh_k1        <= '0;
            sh_k2        <= '0;
            sh_n1        <= '0;
            sh_n2        <= '0;
            pending      <= 1'b0;
            active_valid <= 1'b0;
            ready_q      <= 1'b1;
            muxin1       <= 1'b0;
            sd_reset     <= 1'b1;
            period_tick  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            muxin1      <= (state_d == ST_DWELL1);
            sd_reset    <= (state_d == ST_IDLE) || (state_d == ST_FLUSH);
            busy        <= (state_d != ST_IDLE);
            period_tick <= tick_d;
            // Shadow holds normalised dwells: an all-zero period becomes a single DWELL2 cycle.
            if (accept) begin
                sh_k1   <= cfg.cfg_k1;
                sh_k2   <= cfg.cfg_k2;
                sh_n1   <= cfg.cfg_n1;
                sh_n2   <= ((cfg.cfg_n1 == '0) && (cfg.cfg_n2 == '0)) ? CNTW'(1) : cfg.cfg_n2;
                pending <= 1'b1;
                ready_q <= 1'b0;
            end else if (!pending && !ready_q) begin
                ready_q <= 1'b1;
            end
            if (swap) begin
                kin1         <= sh_k1;
                kin2         <= sh_k2;
                act_n1       <= sh_n1;
                act_n2       <= sh_n2;
                active_valid <= 1'b1;
                pending      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sd_word_scheduler.sv
// Scoreboard bench for sd_word_scheduler: a period-level reference model pushes one
// expected output record per clock edge; a negedge monitor pops and compares.
module tb_sd_word_scheduler;
    localparam int unsigned BW = 40;
    localparam int unsigned CW = 16;
    localparam int unsigned RH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [BW-1:0] kin1, kin2;
    logic          muxin1, sd_reset, period_tick, busy;

    sd_word_scheduler_if #(.BITWIDTH(BW), .CNTW(CW)) cif ();

    sd_word_scheduler #(.BITWIDTH(BW), .CNTW(CW), .RESET_HOLD(RH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg(cif),
        .kin1(kin1), .kin2(kin2), .muxin1(muxin1), .sd_reset(sd_reset),
        .period_tick(period_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] k1;
        logic [BW-1:0] k2;
        logic          mux;
        logic          sdr;
        logic          tick;
        logic          busy;
        logic          rdy;
    } exp_t;
    typedef struct packed { logic mux; logic tick; } slot_t;

    exp_t  exp_q[$];
    slot_t sched[$];
    exp_t  got, want;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    // Reference model: mode 0 idle, 1 flush, 2 running through a precomputed period schedule.
    int          m_mode, flush_left, a_n1, a_n2, s_n1, s_n2;
    logic [BW-1:0] a_k1, a_k2, s_k1, s_k2;
    bit          a_valid, s_pend, m_ready, ready_rise, cur_tick;

    function automatic exp_t cur_exp();
        exp_t e;
        e.k1   = a_k1;
        e.k2   = a_k2;
        e.mux  = (m_mode == 2) ? sched[0].mux : 1'b0;
        e.sdr  = (m_mode != 2);
        e.tick = cur_tick;
        e.busy = (m_mode != 0);
        e.rdy  = m_ready;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = 0; flush_left = 0;
        a_n1 = 0; a_n2 = 0; s_n1 = 0; s_n2 = 0;
        a_k1 = '0; a_k2 = '0; s_k1 = '0; s_k2 = '0;
        a_valid = 0; s_pend = 0; m_ready = 1; ready_rise = 0; cur_tick = 0;
        sched.delete();
    endtask

    task automatic fill_period();
        int n1 = a_n1;
        int n2 = a_n2;
        int total;
        slot_t s;
        if (n1 == 0 && n2 == 0) n2 = 1;
        total = n1 + n2;
        for (int i = 0; i < total; i++) begin
            s.mux  = (i < n1);
            s.tick = (i == total - 1);
            sched.push_back(s);
        end
    endtask

    task automatic model_step();
        bit acc, swp, old_valid;
        int old_mode;
        acc       = cif.cfg_valid && m_ready;
        swp       = s_pend && (m_mode == 0 || cur_tick);
        old_valid = a_valid;
        old_mode  = m_mode;
        if (swp) begin
            a_k1 = s_k1; a_k2 = s_k2; a_n1 = s_n1; a_n2 = s_n2;
            a_valid = 1; s_pend = 0;
        end
        if (acc) begin
            s_k1 = cif.cfg_k1; s_k2 = cif.cfg_k2;
            s_n1 = int'(cif.cfg_n1); s_n2 = int'(cif.cfg_n2);
            s_pend = 1;
            m_ready = 0;
        end else if (ready_rise) begin
            m_ready = 1;
        end
        ready_rise = swp;
        if (!enable) begin
            m_mode = 0;
            sched.delete();
        end else begin
            case (old_mode)
                0: if (old_valid) begin m_mode = 1; flush_left = RH; end
                1: begin
                    flush_left--;
                    if (flush_left == 0) begin m_mode = 2; fill_period(); end
                end
                default: begin
                    void'(sched.pop_front());
                    if (sched.size() == 0) fill_period();
                end
            endcase
        end
        cur_tick = (m_mode == 2) ? sched[0].tick : 1'b0;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset) model_reset();
        else        model_step();
        exp_q.push_back(cur_exp());
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {kin1, kin2, muxin1, sd_reset, period_tick, busy, cif.cfg_ready};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL cycle %0d outputs: got k1=%h k2=%h mux=%b sdr=%b tick=%b busy=%b rdy=%b, want k1=%h k2=%h mux=%b sdr=%b tick=%b busy=%b rdy=%b",
                         cyc, got.k1, got.k2, got.mux, got.sdr, got.tick, got.busy, got.rdy,
                         want.k1, want.k2, want.mux, want.sdr, want.tick, want.busy, want.rdy);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_cfg(input logic [BW-1:0] k1, input logic [BW-1:0] k2,
                            input int n1, input int n2, input bit at_tick);
        int guard = 0;
        while (!(m_ready && (!at_tick || cur_tick)) && guard < 200) begin
            step(1);
            guard++;
        end
        tests++;
        if (guard >= 200) begin
            fails++;
            $display("FAIL send_cfg wait: got no accept window after %0d cycles, want one", guard);
            return;
        end
        cif.cfg_valid = 1'b1;
        cif.cfg_k1 = k1; cif.cfg_k2 = k2;
        cif.cfg_n1 = CW'(n1); cif.cfg_n2 = CW'(n2);
        step(1);
        cif.cfg_valid = 1'b0;
    endtask

    task automatic wait_mux(input bit want_mux);
        int guard = 0;
        while (!(m_mode == 2 && sched[0].mux == want_mux) && guard < 200) begin
            step(1);
            guard++;
        end
        tests++;
        if (guard >= 200) begin
            fails++;
            $display("FAIL wait_mux: got no dwell with muxin1=%b after %0d cycles", want_mux, guard);
        end
    endtask

    task automatic async_reset_check();
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        tests++;
        if ({kin1, kin2, muxin1, sd_reset, period_tick, busy, cif.cfg_ready} !==
            {{BW{1'b0}}, {BW{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL async reset: got k1=%h k2=%h mux=%b sdr=%b tick=%b busy=%b rdy=%b, want all reset values",
                     kin1, kin2, muxin1, sd_reset, period_tick, busy, cif.cfg_ready);
        end
    endtask

    initial begin
        model_reset();
        cif.cfg_valid = 1'b0;
        cif.cfg_k1 = '0; cif.cfg_k2 = '0; cif.cfg_n1 = '0; cif.cfg_n2 = '0;
        step(3);
        reset = 1'b1;
        step(2);
        // Basic 3/5 pattern after the flush.
        enable = 1'b1;
        send_cfg(40'h10_0000_0000, 40'h20_0000_0000, 3, 5, 1'b0);
        step(30);
        // Mid-period reconfiguration waits for the boundary.
        wait_mux(1'b1);
        send_cfg(40'h11_1111_1111, 40'h22_2222_2222, 1, 1, 1'b0);
        step(20);
        // Offer coincident with the tick runs the old pattern one more period.
        send_cfg(40'h33_3333_3333, 40'h44_4444_4444, 3, 2, 1'b1);
        step(20);
        // Skipped dwells.
        send_cfg(40'h55_5555_5555, 40'h66_6666_6666, 0, 2, 1'b0);
        step(12);
        send_cfg(40'h77_7777_7777, 40'h88_8888_8888, 0, 0, 1'b0);
        step(8);
        send_cfg(40'h99_9999_9999, 40'hAA_AAAA_AAAA, 2, 0, 1'b0);
        step(10);
        // Abort in DWELL1 and restart with a fresh flush.
        send_cfg(40'h10_0000_0000, 40'h20_0000_0000, 3, 5, 1'b0);
        wait_mux(1'b1);
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(20);
        // Async reset in DWELL2 with a pending config; enable alone must not restart.
        wait_mux(1'b1);
        send_cfg(40'hBB_BBBB_BBBB, 40'hCC_CCCC_CCCC, 2, 2, 1'b0);
        wait_mux(1'b0);
        async_reset_check();
        step(3);
        reset = 1'b1;
        step(10);
        send_cfg(40'hDD_DDDD_DDDD, 40'hEE_EEEE_EEEE, 4, 3, 1'b0);
        step(25);
        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            enable        = ($urandom_range(0, 29) != 0);
            cif.cfg_valid = ($urandom_range(0, 7) == 0);
            cif.cfg_k1    = BW'({$urandom(), $urandom()});
            cif.cfg_k2    = BW'({$urandom(), $urandom()});
            cif.cfg_n1    = CW'($urandom_range(0, 5));
            cif.cfg_n2    = CW'($urandom_range(0, 5));
            step(1);
        end
        cif.cfg_valid = 1'b0;
        enable = 1'b0;
        step(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
